// File: rtl/fetch_if.sv
// Fetch stage bus bundle: instruction RAM read port, decode handshake and
// control-flow inputs. The fetch stage uses the master modport; the RAM,
// decode and control logic side uses the slave modport.
interface fetch_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [15:0]           mem_rd_data;

  logic [15:0]           inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_valid;
  logic                  inst_ready;

  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  halt;

  modport master (
    output mem_addr, mem_rd_en, inst, inst_pc, inst_valid,
    input  mem_rd_data, inst_ready, jump_en, jump_addr, halt
  );

  modport slave (
    input  mem_addr, mem_rd_en, inst, inst_pc, inst_valid,
    output mem_rd_data, inst_ready, jump_en, jump_addr, halt
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues single-word reads to a
// 1-cycle-latency RAM, buffers responses in a small prefetch FIFO and hands
// them to decode over valid/ready. A read is only issued when the FIFO is
// guaranteed to have room for its response, so a response never finds the
// FIFO full. Jumps flush the FIFO and redirect the PC; halt stops new reads.
module fetch #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic     clk,
  input  logic     rst_async,
  fetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  addr_t         pc_q, pc_d;
  addr_t         tag_q, tag_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   data_d [DEPTH];
  addr_t         addr_q [DEPTH];
  addr_t         addr_d [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;

  // Credit check: occupancy after this cycle's pop plus the pending response
  always_comb begin
    pop   = (count_q != '0) && bus.inst_ready;
    push  = inflight_q && !kill_q && !bus.jump_en;
    occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue = !rst_async && !bus.halt && !bus.jump_en && (occ < DEPTH_C);
  end

  // Next-state: PC advance on issue, FIFO push/pop, jump flush wins over all
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    addr_d     = addr_q;

    if (issue) begin
      pc_d  = pc_q + addr_t'(1);
      tag_d = pc_q;
    end

    if (bus.jump_en) begin
      // A response still in the RAM pipe belongs to the old stream.
      pc_d     = bus.jump_addr;
      kill_d   = inflight_q;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus.mem_rd_data;
        addr_d[wr_ptr_q] = tag_q;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      pc_q       <= RESET_VECTOR;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_q     <= '{default: '0};
      addr_q     <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  // A response must never land on a full FIFO; the credit check prevents it
  always_ff @(posedge clk) begin
    if (!rst_async) begin
      assert (!(push && (count_q == CW'(DEPTH))));
    end
  end

  assign bus.mem_addr   = pc_q;
  assign bus.mem_rd_en  = issue;
  assign bus.inst       = data_q[rd_ptr_q];
  assign bus.inst_pc    = addr_q[rd_ptr_q];
  assign bus.inst_valid = (count_q != '0);
endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: directed timing scenarios plus a randomized run
// checked against an in-order stream model (each accepted instruction must be
// the next address of the current stream, holding that address's RAM word).
module tb_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16 = 1'b1;
  logic rst4  = 1'b1;

  fetch_if #(.ADDR_WIDTH(16)) if16 ();
  fetch_if #(.ADDR_WIDTH(4))  if4 ();

  fetch #(.ADDR_WIDTH(16), .DEPTH(2), .RESET_VECTOR(16'h0000)) dut16 (
    .clk(clk), .rst_async(rst16), .bus(if16)
  );
  fetch #(.ADDR_WIDTH(4), .DEPTH(2), .RESET_VECTOR(4'hE)) dut4 (
    .clk(clk), .rst_async(rst4), .bus(if4)
  );

  logic [15:0] ram16 [65536];
  logic [15:0] ram4  [16];

  // Synchronous RAMs; garbage on the data bus in cycles with no read
  always @(posedge clk) begin
    if16.mem_rd_data <= if16.mem_rd_en ? ram16[if16.mem_addr] : 16'($urandom);
    if4.mem_rd_data  <= if4.mem_rd_en  ? ram4[if4.mem_addr]   : 16'($urandom);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic rdy, input logic hlt, input logic je, input logic [15:0] ja);
    rst16           = 1'b0;
    if16.inst_ready = rdy;
    if16.halt       = hlt;
    if16.jump_en    = je;
    if16.jump_addr  = ja;
  endtask

  task automatic drive4(input logic rdy, input logic hlt, input logic je, input logic [3:0] ja);
    rst4           = 1'b0;
    if4.inst_ready = rdy;
    if4.halt       = hlt;
    if4.jump_en    = je;
    if4.jump_addr  = ja;
  endtask

  task automatic reset16();
    rst16           = 1'b1;
    if16.inst_ready = 1'b0;
    if16.halt       = 1'b0;
    if16.jump_en    = 1'b0;
    if16.jump_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset16();
    rst4 = 1'b1;
    drive4(1'b0, 1'b0, 1'b0, 4'h0);
    rst4 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (if16.inst_valid !== 1'b0 || if16.mem_rd_en !== 1'b0 || if16.inst !== 16'h0 ||
        if16.inst_pc !== 16'h0 || if16.mem_addr !== 16'h0) begin
      n_err++;
      $display("FAIL reset16: valid=%b rd_en=%b inst=%h pc=%h addr=%h want 0/0/0000/0000/0000",
               if16.inst_valid, if16.mem_rd_en, if16.inst, if16.inst_pc, if16.mem_addr);
    end
    n_cmp++;
    if (if4.inst_valid !== 1'b0 || if4.mem_rd_en !== 1'b0 || if4.mem_addr !== 4'hE) begin
      n_err++;
      $display("FAIL reset4: valid=%b rd_en=%b addr=%h want 0/0/e",
               if4.inst_valid, if4.mem_rd_en, if4.mem_addr);
    end
  endtask

  task automatic test_stream();
    reset16();
    for (int c = 0; c < 6; c++) begin
      tick();
      drive16(1'b1, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (if16.mem_rd_en !== 1'b1 || if16.mem_addr !== 16'h0) begin
          n_err++;
          $display("FAIL stream_issue: rd_en=%b addr=%h want 1/0000", if16.mem_rd_en, if16.mem_addr);
        end
      end
      n_cmp++;
      if (c < 2) begin
        if (if16.inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream_latency c%0d: valid=%b want 0", c, if16.inst_valid);
        end
      end else if (if16.inst_valid !== 1'b1 || if16.inst !== ram16[c-2] || if16.inst_pc !== 16'(c-2)) begin
        n_err++;
        $display("FAIL stream c%0d: valid=%b inst=%h pc=%h want 1/%h/%h",
                 c, if16.inst_valid, if16.inst, if16.inst_pc, ram16[c-2], 16'(c-2));
      end
    end
  endtask

  task automatic test_backpressure();
    reset16();
    for (int c = 0; c < 11; c++) begin
      tick();
      drive16(c >= 7, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b1 || if16.inst !== 16'h1001 || if16.inst_pc !== 16'h0 ||
            if16.mem_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL bp_hold c%0d: valid=%b inst=%h pc=%h rd_en=%b want 1/1001/0000/0",
                   c, if16.inst_valid, if16.inst, if16.inst_pc, if16.mem_rd_en);
        end
      end
      if (c >= 7) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b1 || if16.inst !== ram16[c-7] || if16.inst_pc !== 16'(c-7)) begin
          n_err++;
          $display("FAIL bp_release c%0d: valid=%b inst=%h pc=%h want 1/%h/%h",
                   c, if16.inst_valid, if16.inst, if16.inst_pc, ram16[c-7], 16'(c-7));
        end
      end
    end
  endtask

  task automatic test_jump_kill();
    reset16();
    for (int c = 0; c < 9; c++) begin
      tick();
      drive16(1'b1, 1'b0, c == 4, 16'h0040);
      @(negedge clk);
      if (c == 4) begin
        n_cmp++;
        if (if16.mem_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL jump_noissue: rd_en=%b want 0", if16.mem_rd_en);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (if16.mem_rd_en !== 1'b1 || if16.mem_addr !== 16'h0040) begin
          n_err++;
          $display("FAIL jump_reissue: rd_en=%b addr=%h want 1/0040", if16.mem_rd_en, if16.mem_addr);
        end
      end
      if (c == 5 || c == 6) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL jump_flush c%0d: valid=%b want 0", c, if16.inst_valid);
        end
      end
      if (c >= 7) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b1 || if16.inst !== ram16[16'h0040 + 16'(c-7)] ||
            if16.inst_pc !== 16'h0040 + 16'(c-7)) begin
          n_err++;
          $display("FAIL jump_target c%0d: valid=%b inst=%h pc=%h want 1/%h/%h", c, if16.inst_valid,
                   if16.inst, if16.inst_pc, ram16[16'h0040 + 16'(c-7)], 16'h0040 + 16'(c-7));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ja;
    reset16();
    for (int c = 0; c < 10; c++) begin
      tick();
      ja = (c == 3) ? 16'h0010 : 16'h0020;
      drive16(1'b1, 1'b0, c == 3 || c == 4, ja);
      @(negedge clk);
      if (c >= 4 && c <= 6) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_flush c%0d: valid=%b pc=%h want valid 0", c, if16.inst_valid, if16.inst_pc);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (if16.mem_rd_en !== 1'b1 || if16.mem_addr !== 16'h0020) begin
          n_err++;
          $display("FAIL b2b_issue: rd_en=%b addr=%h want 1/0020", if16.mem_rd_en, if16.mem_addr);
        end
      end
      if (c >= 7) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b1 || if16.inst_pc !== 16'h0020 + 16'(c-7) ||
            if16.inst !== ram16[16'h0020 + 16'(c-7)]) begin
          n_err++;
          $display("FAIL b2b_stream c%0d: valid=%b inst=%h pc=%h want 1/%h/%h", c, if16.inst_valid,
                   if16.inst, if16.inst_pc, ram16[16'h0020 + 16'(c-7)], 16'h0020 + 16'(c-7));
        end
      end
    end
  endtask

  task automatic test_halt();
    reset16();
    for (int c = 0; c < 13; c++) begin
      tick();
      drive16(1'b1, c >= 3 && c <= 8, 1'b0, 16'h0);
      @(negedge clk);
      if (c >= 3 && c <= 8) begin
        n_cmp++;
        if (if16.mem_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL halt_noissue c%0d: rd_en=%b want 0", c, if16.mem_rd_en);
        end
      end
      if (c >= 2 && c <= 4) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b1 || if16.inst_pc !== 16'(c-2) || if16.inst !== ram16[c-2]) begin
          n_err++;
          $display("FAIL halt_drain c%0d: valid=%b inst=%h pc=%h want 1/%h/%h",
                   c, if16.inst_valid, if16.inst, if16.inst_pc, ram16[c-2], 16'(c-2));
        end
      end
      if (c >= 5 && c <= 10) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b0) begin
          n_err++;
          $display("FAIL halt_empty c%0d: valid=%b want 0", c, if16.inst_valid);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (if16.mem_rd_en !== 1'b1 || if16.mem_addr !== 16'h0003) begin
          n_err++;
          $display("FAIL halt_resume: rd_en=%b addr=%h want 1/0003", if16.mem_rd_en, if16.mem_addr);
        end
      end
      if (c >= 11) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b1 || if16.inst_pc !== 16'(c-8) || if16.inst !== ram16[c-8]) begin
          n_err++;
          $display("FAIL halt_after c%0d: valid=%b inst=%h pc=%h want 1/%h/%h",
                   c, if16.inst_valid, if16.inst, if16.inst_pc, ram16[c-8], 16'(c-8));
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    logic [3:0] pc;
    rst4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      tick();
      drive4(1'b1, 1'b0, 1'b0, 4'h0);
      @(negedge clk);
      if (c >= 2) begin
        pc = 4'(14 + c - 2);
        n_cmp++;
        if (if4.inst_valid !== 1'b1 || if4.inst_pc !== pc || if4.inst !== ram4[pc]) begin
          n_err++;
          $display("FAIL wrap c%0d: valid=%b inst=%h pc=%h want 1/%h/%h",
                   c, if4.inst_valid, if4.inst, if4.inst_pc, ram4[pc], pc);
        end
      end
    end
    tick();
    rst4 = 1'b1;
    #1;
    n_cmp++;
    if (if4.inst_valid !== 1'b0 || if4.mem_rd_en !== 1'b0 || if4.inst !== 16'h0 || if4.inst_pc !== 4'h0) begin
      n_err++;
      $display("FAIL midreset: valid=%b rd_en=%b inst=%h pc=%h want 0/0/0000/0",
               if4.inst_valid, if4.mem_rd_en, if4.inst, if4.inst_pc);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      drive4(1'b1, 1'b0, 1'b0, 4'h0);
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (if4.mem_rd_en !== 1'b1 || if4.mem_addr !== 4'hE) begin
          n_err++;
          $display("FAIL postreset_issue: rd_en=%b addr=%h want 1/e", if4.mem_rd_en, if4.mem_addr);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (if4.inst_valid !== 1'b1 || if4.inst_pc !== 4'hE || if4.inst !== ram4[14]) begin
          n_err++;
          $display("FAIL postreset_first: valid=%b inst=%h pc=%h want 1/%h/e",
                   if4.inst_valid, if4.inst, if4.inst_pc, ram4[14]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] prev_inst;
    logic [15:0] prev_pc;
    logic        prev_hold;
    logic        rdy, hlt, je;
    logic [15:0] ja;
    int          pops;
    reset16();
    exp_pc    = 16'h0000;
    prev_hold = 1'b0;
    prev_inst = '0;
    prev_pc   = '0;
    pops      = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      rdy = ($urandom_range(0, 3) != 0);
      hlt = ($urandom_range(0, 7) == 0);
      je  = ($urandom_range(0, 39) == 0);
      ja  = 16'($urandom);
      drive16(rdy, hlt, je, ja);
      @(negedge clk);
      n_cmp++;
      if ($isunknown({if16.inst, if16.inst_pc, if16.inst_valid, if16.mem_rd_en, if16.mem_addr})) begin
        n_err++;
        $display("FAIL rand_x c%0d: inst=%h pc=%h valid=%b rd_en=%b want no X",
                 c, if16.inst, if16.inst_pc, if16.inst_valid, if16.mem_rd_en);
      end
      if (hlt || je) begin
        n_cmp++;
        if (if16.mem_rd_en !== 1'b0) begin
          n_err++;
          $display("FAIL rand_noissue c%0d: rd_en=%b want 0 (halt=%b jump=%b)", c, if16.mem_rd_en, hlt, je);
        end
      end
      if (prev_hold) begin
        n_cmp++;
        if (if16.inst_valid !== 1'b1 || if16.inst !== prev_inst || if16.inst_pc !== prev_pc) begin
          n_err++;
          $display("FAIL rand_stable c%0d: valid=%b inst=%h pc=%h want 1/%h/%h",
                   c, if16.inst_valid, if16.inst, if16.inst_pc, prev_inst, prev_pc);
        end
      end
      if (if16.inst_valid === 1'b1 && rdy && !je) begin
        n_cmp++;
        if (if16.inst_pc !== exp_pc || if16.inst !== ram16[exp_pc]) begin
          n_err++;
          $display("FAIL rand_order c%0d: inst=%h pc=%h want %h/%h",
                   c, if16.inst, if16.inst_pc, ram16[exp_pc], exp_pc);
        end
        exp_pc = exp_pc + 16'd1;
        pops++;
      end
      if (je) exp_pc = ja;
      prev_hold = (if16.inst_valid === 1'b1) && !rdy && !je;
      prev_inst = if16.inst;
      prev_pc   = if16.inst_pc;
    end
    n_cmp++;
    if (pops < 300) begin
      n_err++;
      $display("FAIL rand_progress: pops=%0d want at least 300", pops);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram16[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) ram4[i] = 16'($urandom);
    ram16[0]        = 16'h1001;
    ram16[1]        = 16'h2002;
    ram16[2]        = 16'h3003;
    ram16[3]        = 16'h4004;
    ram16[16'h0040] = 16'hBEEF;

    test_reset();
    test_stream();
    test_backpressure();
    test_jump_kill();
    test_back_to_back();
    test_halt();
    test_wrap_reset();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
